// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS pipeline datapath.
//   - default datapath / register-address widths
//   - shift-amount field width
//   - ALU function codes (ALUFun) as carried through ID/EX
//   - bubble function code loaded on flush/reset
package mips_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int SHAMT_W     = 5;
    localparam int ALUFUN_W    = 6;

    localparam logic [ALUFUN_W-1:0] ALU_ADD = 6'b000000;
    localparam logic [ALUFUN_W-1:0] ALU_SUB = 6'b000001;
    localparam logic [ALUFUN_W-1:0] ALU_AND = 6'b011000;
    localparam logic [ALUFUN_W-1:0] ALU_OR  = 6'b011110;
    localparam logic [ALUFUN_W-1:0] ALU_XOR = 6'b010110;
    localparam logic [ALUFUN_W-1:0] ALU_NOR = 6'b010001;
    localparam logic [ALUFUN_W-1:0] ALU_SLL = 6'b100000;
    localparam logic [ALUFUN_W-1:0] ALU_SRL = 6'b100001;
    localparam logic [ALUFUN_W-1:0] ALU_SRA = 6'b100011;
    localparam logic [ALUFUN_W-1:0] ALU_EQ  = 6'b110011;
    localparam logic [ALUFUN_W-1:0] ALU_LT  = 6'b110101;

    // A bubble is an ADD of zeros that never writes back.
    localparam logic [ALUFUN_W-1:0] ALU_BUBBLE = ALU_ADD;

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: selects the most recent value of one source register.
//   addr          register index of the operand
//   stored        value latched in ID/EX
//   mem_regwrite/mem_rd/mem_data   EX/MEM result (highest priority)
//   wb_regwrite/wb_rd/wb_data      MEM/WB result
//   operand       forwarded value
// Register 0 is hard-wired to zero in the register file, so it is never
// forwarded even if an older instruction targets it.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] stored,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] operand
);

    always_comb begin
        operand = stored;
        if (addr != '0) begin
            if (mem_regwrite && (mem_rd == addr)) begin
                operand = mem_data;
            end else if (wb_regwrite && (wb_rd == addr)) begin
                operand = wb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding.
//   clk, reset (async, active-high)       clocking / bubble reset
//   stall, flush                          hold / bubble insertion (flush wins)
//   id_*                                  decoded instruction fields
//   mem_*, wb_*                           later-stage results for forwarding
//   ex_valid, alu_in1, alu_in2, alu_fun,
//   alu_sign, ex_rd, ex_regwrite,
//   ex_store_data                         EX-stage operands and control
// Build option: define FORWARD_EN to enable MEM/WB forwarding. Without it
// the stored rs/rt are used directly and mem_*/wb_* are ignored; hazards
// must then be covered by external stalls.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [5:0]        id_alufun,
    input  logic              id_sign,
    input  logic              id_alusrc1,
    input  logic              id_alusrc2,
    input  logic              id_regwrite,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [5:0]        alu_fun,
    output logic              alu_sign,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic [DATA_W-1:0] ex_store_data
);

`ifdef FORWARD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif

    logic              vld_p1;
    logic [DATA_W-1:0] rs_p1;
    logic [DATA_W-1:0] rt_p1;
    logic [DATA_W-1:0] imm_p1;
    logic [4:0]        shamt_p1;
    logic [REG_AW-1:0] rs_addr_p1;
    logic [REG_AW-1:0] rt_addr_p1;
    logic [REG_AW-1:0] rd_p1;
    logic [5:0]        fun_p1;
    logic              sign_p1;
    logic              src1_p1;
    logic              src2_p1;
    logic              regwrite_p1;

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // With forwarding disabled the write enables are tied low, so both
    // muxes collapse to the stored values and a stall is a plain hold.
    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .addr         (rs_addr_p1),
        .stored       (rs_p1),
        .mem_regwrite (mem_regwrite & FWD_ON),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .wb_regwrite  (wb_regwrite & FWD_ON),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .operand      (rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .addr         (rt_addr_p1),
        .stored       (rt_p1),
        .mem_regwrite (mem_regwrite & FWD_ON),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .wb_regwrite  (wb_regwrite & FWD_ON),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .operand      (rt_fwd)
    );

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush) begin
            vld_p1      <= 1'b0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            imm_p1      <= '0;
            shamt_p1    <= '0;
            rs_addr_p1  <= '0;
            rt_addr_p1  <= '0;
            rd_p1       <= '0;
            fun_p1      <= ALU_BUBBLE;
            sign_p1     <= 1'b0;
            src1_p1     <= 1'b0;
            src2_p1     <= 1'b0;
            regwrite_p1 <= 1'b0;
        end else if (stall) begin
            // Refresh operands so a producer retiring during the stall is
            // not lost once it leaves MEM/WB.
            rs_p1 <= rs_fwd;
            rt_p1 <= rt_fwd;
        end else begin
            vld_p1      <= id_valid;
            rs_p1       <= id_rs_data;
            rt_p1       <= id_rt_data;
            imm_p1      <= id_imm;
            shamt_p1    <= id_shamt;
            rs_addr_p1  <= id_rs_addr;
            rt_addr_p1  <= id_rt_addr;
            rd_p1       <= id_rd_addr;
            fun_p1      <= id_alufun;
            sign_p1     <= id_sign;
            src1_p1     <= id_alusrc1;
            src2_p1     <= id_alusrc2;
            regwrite_p1 <= id_regwrite;
        end
    end

    assign ex_valid      = vld_p1;
    assign alu_in1       = src1_p1 ? {{(DATA_W-SHAMT_W){1'b0}}, shamt_p1} : rs_fwd;
    assign alu_in2       = src2_p1 ? imm_p1 : rt_fwd;
    assign alu_fun       = fun_p1;
    assign alu_sign      = sign_p1;
    assign ex_rd         = rd_p1;
    assign ex_regwrite   = vld_p1 & regwrite_p1;
    assign ex_store_data = rt_fwd;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width.
REQ-003 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have stall  input  1  hold stage contents.
REQ-006 SHALL have flush  input  1  replace next contents with bubble.
REQ-007 SHALL have id_valid  input  1  decode slot holds a real instruction.
REQ-008 SHALL have id_rs_data, id_rt_data  input  DATA_W  register-file read values.
REQ-009 SHALL have id_imm  input  DATA_W  already-extended immediate.
REQ-010 SHALL have id_shamt  input  5  shift amount field.
REQ-011 SHALL have id_rs_addr, id_rt_addr, id_rd_addr  input  REG_AW  source/destination indices.
REQ-012 SHALL have id_alufun  input  6  ALU function code; id_sign  input  1  signed compare/overflow select.
REQ-013 SHALL have id_alusrc1  input  1  in1 = zero-extended shamt; id_alusrc2  input  1  in2 = imm; id_regwrite  input  1.
REQ-014 SHALL have mem_regwrite input 1, mem_rd input REG_AW, mem_data input DATA_W  EX/MEM result for forwarding.
REQ-015 SHALL have wb_regwrite input 1, wb_rd input REG_AW, wb_data input DATA_W  MEM/WB result for forwarding.
REQ-016 SHALL have outputs ex_valid 1, alu_in1 DATA_W, alu_in2 DATA_W, alu_fun 6, alu_sign 1, ex_rd REG_AW, ex_regwrite 1, ex_store_data DATA_W (forwarded rt).

Function
REQ-017 SHALL capture all id_* fields on a clock edge with stall=0, flush=0; outputs reflect them from the next cycle (1-cycle latency).
REQ-018 SHALL on flush=1 load a bubble: ex_valid=0, ex_regwrite=0, alu_fun=6'b000000, data/address registers 0; flush beats stall when both high.
REQ-019 SHALL on stall=1, flush=0 hold control fields and reload stored rs/rt with their current forwarded values, so results leaving MEM/WB during a stall are not lost.
REQ-020 SHALL forward combinationally: source operand = mem_data when mem_regwrite and mem_rd==addr, else wb_data when wb_regwrite and wb_rd==addr, else stored value (MEM priority over WB).
REQ-021 SHALL never forward for register address 0; stored value used.
REQ-022 SHALL drive alu_in1 = {27'b0, shamt} when alusrc1 else forwarded rs; alu_in2 = imm when alusrc2 else forwarded rt.
REQ-023 SHALL drive ex_store_data = forwarded rt regardless of alusrc2.
REQ-024 SHALL gate ex_regwrite with ex_valid (bubble never writes).
REQ-025 SHALL drive alu_fun/alu_sign straight from stored fields; no decoding.

Reset
REQ-026 SHALL on reset=1 immediately clear all registers to bubble state of REQ-018, independent of clk.
REQ-027 SHALL on reset deasserting mid-stream take the first capture at the first rising edge with reset=0.

Configuration
REQ-028 SHALL with FORWARD_EN defined implement REQ-019..021 forwarding.
REQ-029 SHALL without FORWARD_EN use stored rs/rt directly (stall plain hold), mem_*/wb_* ports present but unused; hazards resolved by external stalls.

Structure
REQ-030 SHALL take DATA_W, REG_AW defaults, ALUFun encodings and bubble constant from shared package mips_pkg.
REQ-031 SHALL implement forwarding selection as sub-module fwd_mux, instantiated for rs and rt.

Verification
REQ-032 Capture: id_rs_data=5, id_rt_data=7, alufun=000000, no hazards -> next cycle alu_in1=5, alu_in2=7, ex_valid=1.
REQ-033 MEM priority: stored rs addr 8, mem_rd=8 data 0xAAAA, wb_rd=8 data 0xBBBB, both regwrite -> alu_in1=0xAAAA; mem_regwrite=0 -> 0xBBBB.
REQ-034 Zero register: rs addr 0, mem_rd=0 data 0x1234, regwrite=1 -> alu_in1 = stored value (0).
REQ-035 Stall refresh: stall=1 two cycles, cycle 1 mem_rd=rt with 0x55, cycle 2 no hazard -> alu_in2=0x55 in cycle 2.
REQ-036 Flush+stall both high with valid instruction -> next cycle ex_valid=0, ex_regwrite=0, alu_fun=0.
REQ-037 Async reset pulsed between edges -> all outputs bubble before next rising edge; alusrc1 with shamt=31 after reset -> alu_in1=31.
